// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, next-PC select
// values and the NOP word presented while no instruction is held.
package inst_fetch_unit_pkg;

  typedef enum logic [2:0] {
    IFU_IDLE  = 3'd0,
    IFU_FETCH = 3'd1,
    IFU_WAIT  = 3'd2,
    IFU_HOLD  = 3'd3,
    IFU_ERR   = 3'd4
  } ifu_state_e;

  localparam logic        PC_PLUS_4 = 1'b0;
  localparam logic [31:0] INST_NOP  = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_unit_npc_calc.sv
// Combinational next-PC target: JALR (alu_c, bit 0 cleared), pc+imm, or pc+4.
module inst_fetch_unit_npc_calc
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       imm,
  input  logic [31:0]       alu_c,
  input  logic              npc_op,
  input  logic              pc_sel,
  output logic [ADDR_W-1:0] target
);

  always_comb begin
    if (pc_sel) begin
      target = ADDR_W'(alu_c) & ~ADDR_W'(1);
    end else if (npc_op == PC_PLUS_4) begin
      target = pc + ADDR_W'(4);
    end else begin
      target = pc + ADDR_W'(imm);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Multi-cycle fetch front end: one IMEM request at a time, holds the word until retired.
// Define IFU_MISALIGN_CHK_EN to trap misaligned targets in ERR instead of masking them.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4,
  input  logic              npc_op,
  input  logic              pc_sel,
  input  logic [31:0]       imm,
  input  logic [31:0]       alu_c,
  output logic              fetch_err
);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_pc;
  logic              retire;

  inst_fetch_unit_npc_calc #(
    .ADDR_W (ADDR_W)
  ) u_npc_calc (
    .pc     (pc_q),
    .imm    (imm),
    .alu_c  (alu_c),
    .npc_op (npc_op),
    .pc_sel (pc_sel),
    .target (target)
  );

  assign retire = (state_q == IFU_HOLD) && inst_ready;

`ifdef IFU_MISALIGN_CHK_EN
  assign next_pc = target;
`else
  assign next_pc = target & ~ADDR_W'(3);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IFU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IFU_IDLE:  state_d = IFU_FETCH;
      IFU_FETCH: state_d = IFU_WAIT;
      IFU_WAIT:  if (imem_rvalid) state_d = IFU_HOLD;
      IFU_HOLD: begin
        if (inst_ready) begin
`ifdef IFU_MISALIGN_CHK_EN
          state_d = (target[1:0] != 2'b00) ? IFU_ERR : IFU_FETCH;
`else
          state_d = IFU_FETCH;
`endif
        end
      end
`ifdef IFU_MISALIGN_CHK_EN
      IFU_ERR:   state_d = IFU_ERR;
`endif
      default:   state_d = IFU_IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (state_q == IFU_FETCH);
    inst_valid = (state_q == IFU_HOLD);
`ifdef IFU_MISALIGN_CHK_EN
    fetch_err  = (state_q == IFU_ERR);
`else
    fetch_err  = 1'b0;
`endif
  end

  // rvalid is only honoured in WAIT; anything else on the bus is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      inst_q     <= INST_NOP;
    end else begin
      if ((state_q == IFU_WAIT) && imem_rvalid) begin
        inst_q <= imem_rdata;
        pc_q   <= fetch_pc_q;
      end
      if (retire) begin
        fetch_pc_q <= next_pc;
      end
    end
  end

  assign imem_addr = fetch_pc_q;
  assign inst      = inst_q;
  assign pc        = pc_q;
  assign pc4       = pc_q + ADDR_W'(4);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit; IMEM responses are driven by hand with fixed latencies.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        npc_op;
  logic        pc_sel;
  logic [31:0] imm;
  logic [31:0] alu_c;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  inst_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .pc          (pc),
    .pc4         (pc4),
    .npc_op      (npc_op),
    .pc_sel      (pc_sel),
    .imm         (imm),
    .alu_c       (alu_c),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    inst_ready = 1'b0;
    npc_op     = 1'b0;
    pc_sel     = 1'b0;
    imm        = 32'h0;
    alu_c      = 32'h0;
  endtask

  // Called in the FETCH cycle; answers after lat cycles and checks the held word.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int lat);
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, addr);
    step();
    for (int i = 1; i < lat; i++) begin
      chk("wait_no_dup_req", {31'b0, imem_req}, 32'd0);
      chk("wait_not_valid", {31'b0, inst_valid}, 32'd0);
      step();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hdead_beef;
    chk("hold_valid", {31'b0, inst_valid}, 32'd1);
    chk("hold_inst", inst, word);
    chk("hold_pc", pc, addr);
    chk("hold_pc4", pc4, addr + 32'd4);
  endtask

  task automatic retire(input logic op, input logic sel, input logic [31:0] imm_v,
                        input logic [31:0] alu_v, input logic [31:0] exp_addr);
    inst_ready = 1'b1;
    npc_op     = op;
    pc_sel     = sel;
    imm        = imm_v;
    alu_c      = alu_v;
    step();
    clear_ctl();
    chk("retire_valid_drop", {31'b0, inst_valid}, 32'd0);
    chk("retire_next_req", {31'b0, imem_req}, 32'd1);
    chk("retire_next_addr", imem_addr, exp_addr);
  endtask

  initial begin
    rst         = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    clear_ctl();

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    end
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc4, 32'h4);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);

    rst = 1'b0;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    step();

    // Sequential fetch
    fetch(32'h0, 32'h0050_0093, 1);
    retire(1'b0, 1'b0, 32'h0, 32'h0, 32'h4);

    // Branches: forward to 0x10, then back by 8
    fetch(32'h4, 32'h0000_0013, 1);
    retire(1'b1, 1'b0, 32'h0000_000c, 32'h0, 32'h10);
    fetch(32'h10, 32'hfe00_0ce3, 1);
    retire(1'b1, 1'b0, 32'hffff_fff8, 32'h0, 32'h8);

    // JALR wins over npc_op, bit 0 cleared
    fetch(32'h8, 32'h0000_80e7, 2);
    retire(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0101, 32'h100);

    // Slow memory then backpressure with toggling controls and a stray rvalid
    fetch(32'h100, 32'h0011_0113, 4);
    for (int i = 0; i < 5; i++) begin
      inst_ready  = 1'b0;
      npc_op      = ~npc_op;
      imm         = 32'h0000_1000 + 32'(i);
      imem_rvalid = (i == 2);
      imem_rdata  = 32'hbad0_0000;
      step();
      imem_rvalid = 1'b0;
      chk("bp_inst", inst, 32'h0011_0113);
      chk("bp_pc", pc, 32'h100);
      chk("bp_no_req", {31'b0, imem_req}, 32'd0);
      chk("bp_valid", {31'b0, inst_valid}, 32'd1);
    end
    retire(1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'h104);

    fetch(32'h104, 32'h0000_0067, 1);
`ifdef IFU_MISALIGN_CHK_EN
    inst_ready = 1'b1;
    pc_sel     = 1'b1;
    npc_op     = 1'b0;
    alu_c      = 32'h0000_0106;
    step();
    clear_ctl();
    for (int i = 0; i < 4; i++) begin
      chk("err_flag", {31'b0, fetch_err}, 32'd1);
      chk("err_no_req", {31'b0, imem_req}, 32'd0);
      chk("err_not_valid", {31'b0, inst_valid}, 32'd0);
      step();
    end
    rst = 1'b1;
    step();
    chk("err_rst_clear", {31'b0, fetch_err}, 32'd0);
    rst = 1'b0;
    step();
`else
    retire(1'b0, 1'b1, 32'h0, 32'h0000_0106, 32'h104);
    chk("no_err", {31'b0, fetch_err}, 32'd0);
    fetch(32'h104, 32'h0000_0013, 1);
    retire(1'b1, 1'b0, 32'hffff_fefc, 32'h0, 32'h0);
`endif

    // Address wrap at the top of the space
    fetch(32'h0, 32'h0000_0013, 1);
    retire(1'b0, 1'b1, 32'h0, 32'hffff_fffc, 32'hffff_fffc);
    fetch(32'hffff_fffc, 32'h0000_0013, 1);
    chk("wrap_pc4", pc4, 32'h0);
    retire(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    // Reset while waiting on the fetch at 0x20
    fetch(32'h0, 32'h0020_0213, 1);
    retire(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h20);
    step();
    chk("mid_wait_no_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("mid_rst_inst", inst, 32'h0000_0013);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_pc4", pc4, 32'h4);
    chk("mid_rst_addr", imem_addr, 32'h0);
    step();
    rst = 1'b0;
    chk("post_rst_idle", {31'b0, imem_req}, 32'd0);
    step();
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Multi-cycle instruction fetch front end: owns the PC, issues one request at a time to instruction memory, and holds the returned word stable for the control unit and datapath.
- Consumes the control unit's next-PC decisions (npc_op, pc_sel) plus the sign-extended immediate and ALU result, and computes the next fetch address.
- Sits between IMEM and the decode/control stage.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
ADDR_W, 32, PC/address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  one-cycle fetch request pulse
imem_addr  out  ADDR_W  fetch address; valid when imem_req=1
imem_rvalid  in  1  read data valid; earliest one cycle after imem_req
imem_rdata  in  32  instruction word
inst_valid  out  1  inst/pc/pc4 hold a valid instruction
inst_ready  in  1  consumer retires the held instruction this cycle
inst  out  32  held instruction word
pc  out  ADDR_W  address of held instruction
pc4  out  ADDR_W  pc+4, used for link writeback
npc_op  in  1  0: pc+4; 1: pc+imm (branch taken / JAL)
pc_sel  in  1  1: JALR target from alu_c; overrides npc_op
imm  in  32  sign-extended immediate
alu_c  in  32  ALU result, JALR target
fetch_err  out  1  misaligned-target flag; constant 0 unless the macro is defined

Behaviour:
- Reset (async, while rst=1):
  - State IDLE; imem_req=0; imem_addr=RESET_PC; inst_valid=0; inst=32'h0000_0013 (NOP); pc=RESET_PC; pc4=RESET_PC+4; fetch_err=0.
- FSM states: IDLE, FETCH, WAIT, HOLD, ERR.
- IDLE: exactly one cycle after reset release, then FETCH.
- FETCH:
  - imem_req=1 for exactly this cycle; imem_addr=fetch PC.
  - Next state WAIT unconditionally.
- WAIT:
  - imem_req=0; stays in WAIT until imem_rvalid=1.
  - On rvalid: register imem_rdata into inst, set pc to the fetch PC, go to HOLD.
  - inst_valid rises the following cycle.
  - imem_rvalid outside WAIT is ignored.
- HOLD:
  - inst_valid=1; inst, pc and pc4 are stable.
  - npc_op, pc_sel, imm and alu_c are sampled only in a cycle where inst_ready=1.
  - Retire (inst_ready=1): target = pc_sel ? (alu_c & ~1) : npc_op ? pc+imm : pc+4. Target is latched as the fetch PC; inst_valid drops next cycle; go to FETCH.
  - inst_ready=0: hold indefinitely, with no requests issued.
- Throughput:
  - One instruction per 3 cycles minimum: FETCH, WAIT with rvalid, HOLD with ready.
  - Each extra IMEM latency cycle adds one cycle.
- Arithmetic: all address sums are modulo 2^ADDR_W; wrap from 0xFFFF_FFFC+4 gives 0x0 silently.
- Only one request is outstanding at a time. IMEM shares rst, so no response from before a reset can arrive after it.
- Reset mid-WAIT or mid-HOLD: immediate return to reset values; the held instruction is discarded.
- ERR: entered only with the optional feature enabled. No requests, inst_valid=0, fetch_err=1 until reset.

Optional Feature:
- Macro: IFU_MISALIGN_CHK_EN.
- Defined: on retire, if target[1:0]!=2'b00, enter ERR instead of FETCH. fetch_err goes high the next cycle and stays high.
- Undefined: target[1:0] is forced to 2'b00 before latching; fetch_err is tied to 0 and the ERR state is not synthesized.

Decomposition:
- Shared parameter header holds:
  - State encodings (IFU_IDLE, IFU_FETCH, IFU_WAIT, IFU_HOLD, IFU_ERR).
  - Existing next-PC select constant PC_PLUS_4.
  - NOP encoding 32'h0000_0013.
- One sub-module, npc_calc: purely combinational target computation from pc, imm, alu_c, npc_op and pc_sel.
- inst_fetch_unit keeps the FSM and all registers.

Test Plan:
- Reset and first fetch: hold rst=1 for 3 cycles, then release → imem_req=0 and inst_valid=0 during reset; one idle cycle; then imem_req=1 with imem_addr=0x0000_0000.
- Sequential fetch: respond 0x0050_0093 one cycle after req; inst_ready=1, npc_op=0 → inst=0x0050_0093, pc=0x0, pc4=0x4; next req at addr 0x0000_0004.
- Taken branch: at pc=0x10, npc_op=1, imm=0xFFFF_FFF8, inst_ready=1 → next imem_addr=0x0000_0008.
- JALR and misalignment:
  - pc_sel=1, npc_op=1, alu_c=0x0000_0101 → addr 0x0000_0100 (pc_sel wins).
  - alu_c=0x0000_0106 with macro defined → fetch_err=1, no further imem_req.
  - Same alu_c with macro undefined → addr 0x0000_0104.
- Backpressure and slow memory:
  - rvalid delayed 4 cycles → single req pulse, no duplicate.
  - Then inst_ready=0 for 5 cycles while npc_op/imm toggle → inst/pc stable, no req; release ready with npc_op=0 → next addr pc+4.
- Reset mid-operation: assert rst during WAIT at pc=0x20 → outputs return to reset values the same cycle; after release, first req at 0x0000_0000.
